// File: rtl/seq_equiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_equiv_pkg
// Purpose  : Shared types and helpers for the sequential equivalence
//            scoreboard (error codes, verdict states, timestamp width).
// Revision : 1.0 - initial release
// ============================================================================
package seq_equiv_pkg;

  // Error codes reported on err_code / first_code
  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_MISMATCH = 3'd1,
    ERR_OVERFLOW = 3'd2,
    ERR_TIMEOUT  = 3'd3,
    ERR_LATENCY  = 3'd4
  } err_code_e;

  // End-of-test verdict controller states
  typedef enum logic [1:0] {
    SB_RUN   = 2'd0,
    SB_DRAIN = 2'd1,
    SB_PASS  = 2'd2,
    SB_FAIL  = 2'd3
  } sb_state_e;

  // Timestamp width: one bit of headroom above what MAX_SKEW needs, so the
  // modular age of a live entry never aliases before the timeout fires.
  function automatic int ts_width(input int max_skew);
    return $clog2(max_skew + 1) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_equiv_chan.sv
`default_nettype none
// ============================================================================
// Module   : seq_equiv_chan
// Purpose  : One scoreboard channel. Queues whichever side runs ahead, pairs
//            entries in order with the lagging side, and reports the highest
//            priority error for the current cycle (combinational outputs).
// Revision : 1.0 - initial release
// ============================================================================
module seq_equiv_chan
  import seq_equiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int MAX_SKEW   = 16,
  parameter int LOCKSTEP   = 0,
  parameter int TS_W       = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [TS_W-1:0]       ts_now,
  input  logic                  orig_valid,
  input  logic [DATA_WIDTH-1:0] orig_data,
  input  logic                  opt_valid,
  input  logic [DATA_WIDTH-1:0] opt_data,
  output err_code_e             ch_code,
  output logic [DATA_WIDTH-1:0] ch_exp,
  output logic [DATA_WIDTH-1:0] ch_act,
  output logic                  ch_match,
  output logic                  ch_idle_nxt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);
  localparam logic [TS_W-1:0]  c_max_skew = TS_W'(MAX_SKEW);

  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [TS_W-1:0]       r_mem_ts   [DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_lead;          // 0 = orig queued, 1 = opt queued
  logic                  r_head_flagged;  // head already reported as timed out

  logic                  w_ov;
  logic                  w_pv;
  logic                  w_empty;
  logic                  w_lead_v;
  logic                  w_lag_v;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_direct;
  logic                  w_overflow;
  logic                  w_push_side;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [TS_W-1:0]       w_head_ts;
  logic [TS_W-1:0]       w_age;
  logic                  w_timeout;
  logic [DATA_WIDTH-1:0] w_cmp_exp;
  logic [DATA_WIDTH-1:0] w_cmp_act;
  logic                  w_mismatch;
  logic [CNT_W-1:0]      w_count_nxt;

  // Queue control: decide push/pop/direct compare; clr masks every input
  always_comb begin
    w_ov        = orig_valid & ~clr;
    w_pv        = opt_valid & ~clr;
    w_empty     = (r_count == '0);
    w_head_data = r_mem_data[r_rd_ptr];
    w_head_ts   = r_mem_ts[r_rd_ptr];
    w_lead_v    = r_lead ? w_pv : w_ov;
    w_lag_v     = r_lead ? w_ov : w_pv;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_direct    = 1'b0;
    w_overflow  = 1'b0;
    if (w_empty) begin
      w_direct = w_ov & w_pv;
      w_push   = w_ov ^ w_pv;
    end else begin
      w_pop      = w_lag_v;
      // A pop in the same cycle frees a slot, so a full queue can still accept
      w_overflow = w_lead_v & (r_count == c_depth) & ~w_lag_v;
      w_push     = w_lead_v & ~w_overflow;
    end
    w_push_side = w_empty ? w_pv : r_lead;
    w_push_data = w_push_side ? opt_data : orig_data;
    w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    ch_idle_nxt = (w_count_nxt == '0);
  end

  // Compare, timeout and error-code selection for this cycle
  always_comb begin
    w_cmp_exp = orig_data;
    w_cmp_act = opt_data;
    if (w_pop) begin
      if (r_lead) w_cmp_act = w_head_data;
      else        w_cmp_exp = w_head_data;
    end
    w_mismatch = (w_direct | w_pop) & (w_cmp_exp != w_cmp_act);
    ch_match   = (w_direct | w_pop) & (w_cmp_exp == w_cmp_act);
    w_age      = ts_now - w_head_ts;
    w_timeout  = ~clr & ~w_empty & ~r_head_flagged & (w_age >= c_max_skew);

    ch_code = ERR_NONE;
    ch_exp  = '0;
    ch_act  = '0;
    if (w_mismatch) begin
      ch_code = ERR_MISMATCH;
      ch_exp  = w_cmp_exp;
      ch_act  = w_cmp_act;
    end else if (w_timeout) begin
      ch_code = ERR_TIMEOUT;
      if (r_lead) ch_act = w_head_data;
      else        ch_exp = w_head_data;
    end else if (w_overflow) begin
      ch_code = ERR_OVERFLOW;
      if (r_lead) ch_act = opt_data;
      else        ch_exp = orig_data;
    end else if ((LOCKSTEP != 0) && (w_count_nxt != '0)) begin
      ch_code = ERR_LATENCY;
    end
  end

  // Pointer, count, lead and timeout-flag state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_count        <= '0;
      r_lead         <= 1'b0;
      r_head_flagged <= 1'b0;
    end else if (clr) begin
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_count        <= '0;
      r_lead         <= 1'b0;
      r_head_flagged <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      if (w_empty && w_push) r_lead <= w_pv;
      if (w_pop)          r_head_flagged <= 1'b0;
      else if (w_timeout) r_head_flagged <= 1'b1;
    end
  end

  // Queue storage: payload plus arrival timestamp, no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_push_data;
      r_mem_ts[r_wr_ptr]   <= ts_now;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_equiv_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : seq_equiv_scoreboard
// Purpose  : Multi-channel latency-tolerant equivalence scoreboard. Combines
//            per-channel results into a registered error pulse, first-error
//            capture, saturating match counter and a run/drain verdict FSM.
// Revision : 1.0 - initial release
// ============================================================================
module seq_equiv_scoreboard
  import seq_equiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 8,
  parameter int MAX_SKEW   = 16,
  parameter int LOCKSTEP   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic [NUM_CH-1:0]            orig_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] orig_data,
  input  logic [NUM_CH-1:0]            opt_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] opt_data,
  input  logic                         eot,
  output logic                         err,
  output logic [2:0]                   err_code,
  output logic [$clog2(NUM_CH)-1:0]    err_ch,
  output logic [2:0]                   first_code,
  output logic [$clog2(NUM_CH)-1:0]    first_ch,
  output logic [DATA_WIDTH-1:0]        first_exp,
  output logic [DATA_WIDTH-1:0]        first_act,
  output logic [31:0]                  match_cnt,
  output logic [1:0]                   state
);

  localparam int TS_W  = ts_width(MAX_SKEW);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int SUM_W = $clog2(NUM_CH + 1);

  logic [TS_W-1:0]       r_ts;
  logic                  r_err;
  err_code_e             r_err_code;
  logic [CH_W-1:0]       r_err_ch;
  err_code_e             r_first_code;
  logic [CH_W-1:0]       r_first_ch;
  logic [DATA_WIDTH-1:0] r_first_exp;
  logic [DATA_WIDTH-1:0] r_first_act;
  logic [31:0]           r_match_cnt;
  sb_state_e             r_state;

  err_code_e             w_code [NUM_CH];
  logic [DATA_WIDTH-1:0] w_exp  [NUM_CH];
  logic [DATA_WIDTH-1:0] w_act  [NUM_CH];
  logic [NUM_CH-1:0]     w_match;
  logic [NUM_CH-1:0]     w_idle;

  err_code_e             w_sel_code;
  logic [CH_W-1:0]       w_sel_ch;
  logic [DATA_WIDTH-1:0] w_sel_exp;
  logic [DATA_WIDTH-1:0] w_sel_act;
  logic                  w_any_err;
  logic [SUM_W-1:0]      w_match_sum;
  logic [32:0]           w_match_ext;
  logic [31:0]           w_match_nxt;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      seq_equiv_chan #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .MAX_SKEW   (MAX_SKEW),
        .LOCKSTEP   (LOCKSTEP),
        .TS_W       (TS_W)
      ) u_chan (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .ts_now      (r_ts),
        .orig_valid  (orig_valid[c]),
        .orig_data   (orig_data[c*DATA_WIDTH +: DATA_WIDTH]),
        .opt_valid   (opt_valid[c]),
        .opt_data    (opt_data[c*DATA_WIDTH +: DATA_WIDTH]),
        .ch_code     (w_code[c]),
        .ch_exp      (w_exp[c]),
        .ch_act      (w_act[c]),
        .ch_match    (w_match[c]),
        .ch_idle_nxt (w_idle[c])
      );
    end
  endgenerate

  // Lowest-index channel with an error wins; scan downward so it lands last
  always_comb begin
    w_sel_code = ERR_NONE;
    w_sel_ch   = '0;
    w_sel_exp  = '0;
    w_sel_act  = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (w_code[c] != ERR_NONE) begin
        w_sel_code = w_code[c];
        w_sel_ch   = CH_W'(c);
        w_sel_exp  = w_exp[c];
        w_sel_act  = w_act[c];
      end
    end
    w_any_err = (w_sel_code != ERR_NONE);
  end

  // Several channels can match in one cycle; add them and saturate
  always_comb begin
    w_match_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_match_sum = w_match_sum + SUM_W'(w_match[c]);
    end
    w_match_ext = {1'b0, r_match_cnt} + 33'(w_match_sum);
    w_match_nxt = w_match_ext[32] ? '1 : w_match_ext[31:0];
  end

  // Free-running arrival timestamp shared by all channels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_ts <= '0;
    else if (clr) r_ts <= '0;
    else          r_ts <= r_ts + TS_W'(1);
  end

  // Registered error reporting, first-error capture, counter and verdict FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_err_ch     <= '0;
      r_first_code <= ERR_NONE;
      r_first_ch   <= '0;
      r_first_exp  <= '0;
      r_first_act  <= '0;
      r_match_cnt  <= '0;
      r_state      <= SB_RUN;
    end else if (clr) begin
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_err_ch     <= '0;
      r_first_code <= ERR_NONE;
      r_first_ch   <= '0;
      r_first_exp  <= '0;
      r_first_act  <= '0;
      r_match_cnt  <= '0;
      r_state      <= SB_RUN;
    end else begin
      r_err       <= w_any_err;
      r_err_code  <= w_sel_code;
      r_err_ch    <= w_sel_ch;
      r_match_cnt <= w_match_nxt;
      if (w_any_err && (r_first_code == ERR_NONE)) begin
        r_first_code <= w_sel_code;
        r_first_ch   <= w_sel_ch;
        r_first_exp  <= w_sel_exp;
        r_first_act  <= w_sel_act;
      end
      case (r_state)
        SB_RUN: begin
          if (w_any_err) r_state <= SB_FAIL;
          else if (eot)  r_state <= SB_DRAIN;
        end
        SB_DRAIN: begin
          if (w_any_err)    r_state <= SB_FAIL;
          else if (&w_idle) r_state <= SB_PASS;
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign err        = r_err;
  assign err_code   = r_err_code;
  assign err_ch     = r_err_ch;
  assign first_code = r_first_code;
  assign first_ch   = r_first_ch;
  assign first_exp  = r_first_exp;
  assign first_act  = r_first_act;
  assign match_cnt  = r_match_cnt;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_seq_equiv_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_equiv_scoreboard
// Purpose  : Self-checking bench for seq_equiv_scoreboard. Two instances:
//            latency tolerant (LOCKSTEP=0) and lockstep (LOCKSTEP=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_equiv_scoreboard;

  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam logic [1:0] S_RUN = 2'd0, S_DRN = 2'd1, S_PAS = 2'd2, S_BAD = 2'd3;

  typedef struct packed {
    logic        sel;      // 0 = latency-tolerant instance, 1 = lockstep
    logic        clr;
    logic        eot;
    logic [3:0]  ov;
    logic [31:0] od;       // channel c carries od + c
    logic [3:0]  pv;
    logic [31:0] pd;       // channel c carries pd + c
    logic        e_err;
    logic [2:0]  e_code;
    logic [1:0]  e_ch;
    logic [31:0] e_match;
    logic [1:0]  e_state;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic m_clr, m_eot, l_clr, l_eot;
  logic [NCH-1:0] m_ov, m_pv, l_ov, l_pv;
  logic [NCH*DW-1:0] m_od, m_pd, l_od, l_pd;

  logic m_err, l_err;
  logic [2:0] m_err_code, l_err_code, m_first_code, l_first_code;
  logic [1:0] m_err_ch, l_err_ch, m_first_ch, l_first_ch, m_state, l_state;
  logic [DW-1:0] m_first_exp, m_first_act, l_first_exp, l_first_act;
  logic [31:0] m_match, l_match;

  seq_equiv_scoreboard #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(8), .MAX_SKEW(16), .LOCKSTEP(0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(m_clr),
    .orig_valid(m_ov), .orig_data(m_od), .opt_valid(m_pv), .opt_data(m_pd), .eot(m_eot),
    .err(m_err), .err_code(m_err_code), .err_ch(m_err_ch),
    .first_code(m_first_code), .first_ch(m_first_ch), .first_exp(m_first_exp), .first_act(m_first_act),
    .match_cnt(m_match), .state(m_state)
  );

  seq_equiv_scoreboard #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(8), .MAX_SKEW(16), .LOCKSTEP(1)) dut_ls (
    .clk(clk), .rst_n(rst_n), .clr(l_clr),
    .orig_valid(l_ov), .orig_data(l_od), .opt_valid(l_pv), .opt_data(l_pd), .eot(l_eot),
    .err(l_err), .err_code(l_err_code), .err_ch(l_err_ch),
    .first_code(l_first_code), .first_ch(l_first_ch), .first_exp(l_first_exp), .first_act(l_first_act),
    .match_cnt(l_match), .state(l_state)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   vec_id   = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic sel, input logic clr, input logic eot,
                              input logic [3:0] ov, input logic [31:0] od,
                              input logic [3:0] pv, input logic [31:0] pd,
                              input logic e_err, input logic [2:0] e_code, input logic [1:0] e_ch,
                              input logic [31:0] e_match, input logic [1:0] e_state);
    vec_t v;
    v.sel = sel; v.clr = clr; v.eot = eot; v.ov = ov; v.od = od; v.pv = pv; v.pd = pd;
    v.e_err = e_err; v.e_code = e_code; v.e_ch = e_ch; v.e_match = e_match; v.e_state = e_state;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    logic [NCH*DW-1:0] od, pd;
    for (int c = 0; c < NCH; c++) begin
      od[c*DW +: DW] = v.od + 32'(c);
      pd[c*DW +: DW] = v.pd + 32'(c);
    end
    m_clr = v.sel ? 1'b0 : v.clr;  l_clr = v.sel ? v.clr : 1'b0;
    m_eot = v.sel ? 1'b0 : v.eot;  l_eot = v.sel ? v.eot : 1'b0;
    m_ov  = v.sel ? '0 : v.ov;     l_ov  = v.sel ? v.ov : '0;
    m_pv  = v.sel ? '0 : v.pv;     l_pv  = v.sel ? v.pv : '0;
    m_od  = od; m_pd = pd; l_od = od; l_pd = pd;
  endtask

  // Pop the oldest expectation and compare against the selected instance
  task automatic check_front();
    vec_t e;
    e = exp_q.pop_front();
    if (e.sel == 1'b0) begin
      chk("err", vec_id, 64'(m_err), 64'(e.e_err));
      chk("err_code", vec_id, 64'(m_err_code), 64'(e.e_code));
      if (e.e_err) chk("err_ch", vec_id, 64'(m_err_ch), 64'(e.e_ch));
      chk("match_cnt", vec_id, 64'(m_match), 64'(e.e_match));
      chk("state", vec_id, 64'(m_state), 64'(e.e_state));
    end else begin
      chk("ls_err", vec_id, 64'(l_err), 64'(e.e_err));
      chk("ls_err_code", vec_id, 64'(l_err_code), 64'(e.e_code));
      if (e.e_err) chk("ls_err_ch", vec_id, 64'(l_err_ch), 64'(e.e_ch));
      chk("ls_match_cnt", vec_id, 64'(l_match), 64'(e.e_match));
      chk("ls_state", vec_id, 64'(l_state), 64'(e.e_state));
    end
    vec_id++;
  endtask

  task automatic apply(input vec_t v);
    drive(v);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_err"}, vec_id, 64'(m_err) | 64'(l_err), 64'd0);
    chk({tag, "_err_code"}, vec_id, 64'(m_err_code) | 64'(l_err_code), 64'd0);
    chk({tag, "_err_ch"}, vec_id, 64'(m_err_ch) | 64'(l_err_ch), 64'd0);
    chk({tag, "_first_code"}, vec_id, 64'(m_first_code) | 64'(l_first_code), 64'd0);
    chk({tag, "_first_ch"}, vec_id, 64'(m_first_ch) | 64'(l_first_ch), 64'd0);
    chk({tag, "_first_exp"}, vec_id, 64'(m_first_exp) | 64'(l_first_exp), 64'd0);
    chk({tag, "_first_act"}, vec_id, 64'(m_first_act) | 64'(l_first_act), 64'd0);
    chk({tag, "_match_cnt"}, vec_id, 64'(m_match) | 64'(l_match), 64'd0);
    chk({tag, "_state"}, vec_id, 64'(m_state) | 64'(l_state), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog @%0d actual=timeout required=finish", vec_id);
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            sel clr eot ov     od        pv     pd        err code ch  match  state
    tbl.push_back(mk(0, 0, 0, 4'h1, 32'hA5,  4'h0, 32'h0,   0, 0, 0, 0, S_RUN));  // ch0 orig leads
    tbl.push_back(mk(0, 0, 0, 4'h0, 32'h0,   4'h0, 32'h0,   0, 0, 0, 0, S_RUN));
    tbl.push_back(mk(0, 0, 0, 4'h0, 32'h0,   4'h0, 32'h0,   0, 0, 0, 0, S_RUN));
    tbl.push_back(mk(0, 0, 0, 4'h0, 32'h0,   4'h1, 32'hA5,  0, 0, 0, 1, S_RUN));  // opt 3 later
    tbl.push_back(mk(0, 0, 0, 4'hF, 32'h100, 4'hF, 32'h100, 0, 0, 0, 5, S_RUN));  // 4 direct matches
    tbl.push_back(mk(0, 0, 0, 4'h2, 32'h0F,  4'h2, 32'h10,  1, 1, 1, 5, S_BAD));  // ch1 0x10 vs 0x11
    tbl.push_back(mk(0, 0, 0, 4'h5, 32'h0,   4'h5, 32'h100, 1, 1, 0, 5, S_BAD));  // ch0+ch2 -> ch0
    tbl.push_back(mk(0, 0, 0, 4'h1, 32'h5,   4'h1, 32'h5,   0, 0, 0, 6, S_BAD));  // compares continue
    tbl.push_back(mk(0, 1, 0, 4'hF, 32'h7,   4'hF, 32'h8,   0, 0, 0, 0, S_RUN));  // clr masks inputs
    tbl.push_back(mk(0, 0, 1, 4'h1, 32'h3,   4'h0, 32'h0,   0, 0, 0, 0, S_DRN));  // eot, entry queued
    tbl.push_back(mk(0, 0, 0, 4'h0, 32'h0,   4'h0, 32'h0,   0, 0, 0, 0, S_DRN));  // waits for drain
    tbl.push_back(mk(0, 0, 0, 4'h0, 32'h0,   4'h1, 32'h3,   0, 0, 0, 1, S_PAS));
    tbl.push_back(mk(0, 0, 0, 4'h2, 32'h0,   4'h2, 32'h0,   0, 0, 0, 2, S_PAS));
    tbl.push_back(mk(0, 1, 0, 4'h0, 32'h0,   4'h0, 32'h0,   0, 0, 0, 0, S_RUN));
    tbl.push_back(mk(0, 0, 1, 4'h1, 32'h1,   4'h1, 32'h2,   1, 1, 0, 0, S_BAD));  // error beats eot
    tbl.push_back(mk(0, 1, 0, 4'h0, 32'h0,   4'h0, 32'h0,   0, 0, 0, 0, S_RUN));
    tbl.push_back(mk(1, 0, 0, 4'h1, 32'h9,   4'h0, 32'h0,   1, 4, 0, 0, S_BAD));  // lockstep latency
    tbl.push_back(mk(1, 0, 0, 4'h0, 32'h0,   4'h1, 32'h9,   0, 0, 0, 1, S_BAD));
    tbl.push_back(mk(1, 1, 0, 4'h0, 32'h0,   4'h0, 32'h0,   0, 0, 0, 0, S_RUN));
    tbl.push_back(mk(1, 0, 0, 4'hF, 32'h20,  4'hF, 32'h20,  0, 0, 0, 4, S_RUN));
    tbl.push_back(mk(1, 0, 1, 4'h0, 32'h0,   4'h0, 32'h0,   0, 0, 0, 4, S_DRN));
    tbl.push_back(mk(1, 0, 0, 4'h0, 32'h0,   4'h0, 32'h0,   0, 0, 0, 4, S_PAS));
    tbl.push_back(mk(1, 0, 0, 4'h0, 32'h0,   4'h0, 32'h0,   0, 0, 0, 4, S_PAS));

    rst_n = 1'b0;
    drive(mk(0, 0, 0, 4'h0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 0, S_RUN));
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      if (i == 6) begin
        chk("first_code", i, 64'(m_first_code), 64'd1);
        chk("first_ch", i, 64'(m_first_ch), 64'd1);
        chk("first_exp", i, 64'(m_first_exp), 64'h10);
        chk("first_act", i, 64'(m_first_act), 64'h11);
      end
    end

    // Overflow: nine orig pushes on ch2, ninth is dropped
    for (int i = 0; i < 9; i++)
      apply(mk(0, 0, 0, 4'h4, 32'(i * 16), 4'h0, 32'h0,
               (i == 8), (i == 8) ? 3'd2 : 3'd0, 2'd2, 0, (i == 8) ? S_BAD : S_RUN));
    // Drain the eight retained entries in order
    for (int i = 0; i < 8; i++)
      apply(mk(0, 0, 0, 4'h0, 32'h0, 4'h4, 32'(i * 16), 0, 0, 0, 32'(i + 1), S_BAD));
    // Queue now empty: a lone opt value is queued, not compared
    apply(mk(0, 0, 0, 4'h0, 32'h0, 4'h4, 32'h999, 0, 0, 0, 8, S_BAD));
    apply(mk(0, 1, 0, 4'h0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 0, S_RUN));

    // Timeout: one ch3 entry, opt silent; flagged once at age 16
    apply(mk(0, 0, 0, 4'h8, 32'h30, 4'h0, 32'h0, 0, 0, 0, 0, S_RUN));
    for (int i = 1; i <= 20; i++)
      apply(mk(0, 0, 0, 4'h0, 32'h0, 4'h0, 32'h0,
               (i == 16), (i == 16) ? 3'd3 : 3'd0, 2'd3, 0, (i >= 16) ? S_BAD : S_RUN));
    apply(mk(0, 1, 0, 4'h0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 0, S_RUN));

    // Asynchronous reset with an entry queued
    apply(mk(0, 0, 0, 4'h2, 32'h0, 4'h2, 32'h0, 0, 0, 0, 1, S_RUN));
    apply(mk(0, 0, 0, 4'h1, 32'h44, 4'h0, 32'h0, 0, 0, 0, 1, S_RUN));
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(0, 0, 0, 4'h0, 32'h0, 4'h1, 32'h44, 0, 0, 0, 0, S_RUN));
    apply(mk(0, 0, 0, 4'h0, 32'h0, 4'h1, 32'h45, 0, 0, 0, 0, S_RUN));

    chk("queue_empty", vec_id, 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
